// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Contents: PC/instruction widths, PC step, FIFO entry type, FSM state
// enum and a PC word-alignment helper.
package ifetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return a & ~(PC_W'(3));
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// master (fetch unit): drives imem_pc_o/imem_we_o to memory and
//   instr_o/pc_o/valid_o to decode; receives imem_instr_i and ready_i.
// slave (memory + decode side): the mirror image.
interface ifetch_if;
  import ifetch_pkg::*;

  logic [PC_W-1:0]    imem_pc_o;
  logic               imem_we_o;
  logic [INSTR_W-1:0] imem_instr_i;
  logic [INSTR_W-1:0] instr_o;
  logic [PC_W-1:0]    pc_o;
  logic               valid_o;
  logic               ready_i;

  modport master (
    output imem_pc_o, imem_we_o, instr_o, pc_o, valid_o,
    input  imem_instr_i, ready_i
  );

  modport slave (
    input  imem_pc_o, imem_we_o, instr_o, pc_o, valid_o,
    output imem_instr_i, ready_i
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Response FIFO for fetched {instr, pc} entries.
// Shift-register organisation: entry 0 is always the head, so the head
// comes straight from a register.
// Ports: clk_i, aresetn_i (async active-low), push_i/push_data_i,
//   pop_i, flush_i (priority over push and pop), head_o, count_o,
//   full_o, empty_o.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         aresetn_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CNT_W-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t      ent_q [DEPTH];
  fetch_entry_t      ent_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  wr_idx;
  logic              pop_eff;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = ent_q[0];
  assign pop_eff = pop_i && !empty_o;
  // A push in the same cycle as a pop lands one slot lower, after the shift.
  assign wr_idx  = cnt_q - CNT_W'(pop_eff);

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      if (pop_eff) begin
        for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
      end
      if (push_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == wr_idx) ent_d[i] = push_data_i;
        end
      end
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end.
// Issues sequential word reads to a synchronous SRAM (data one cycle
// after the address), buffers returned words with their PCs in a small
// FIFO so decode back-pressure never drops data, and flushes on redirect.
// Ports: clk_i, aresetn_i (async active-low), fetch_en_i (level),
//   redirect_valid_i/redirect_pc_i (redirect strobe + target),
//   bus (ifetch_if.master: imem_pc_o, imem_we_o, imem_instr_i,
//   instr_o, pc_o, valid_o, ready_i).
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            aresetn_i,
  input  logic            fetch_en_i,
  input  logic            redirect_valid_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  ifetch_if.master        bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_q;
  logic [PC_W-1:0]   next_pc_q;
  logic              rsp_v_q;
  logic [PC_W-1:0]   rsp_pc_q;

  logic [PC_W-1:0]   tgt;
  logic              pop, redir_issue, seq_issue;
  logic [CNT_W:0]    occ;
  logic              fifo_push, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      fifo_head, push_data;

  assign tgt = align_pc(redirect_pc_i);
  assign pop = bus.valid_o && bus.ready_i;

  // Occupancy after this cycle's push/pop; the read issued now lands one
  // cycle later, so it must still find a free slot.
  assign occ = {1'b0, fifo_count} + (CNT_W+1)'(rsp_v_q) - (CNT_W+1)'(pop);

  assign redir_issue = redirect_valid_i && ((state_q == RUN) || fetch_en_i);
  assign seq_issue   = !redirect_valid_i && (state_q == RUN) && fetch_en_i &&
                       (occ < (CNT_W+1)'(DEPTH));

  assign bus.imem_pc_o = redir_issue ? tgt : next_pc_q;
  assign bus.imem_we_o = 1'b0;

  // A redirect kills the response arriving this cycle.
  assign fifo_push = rsp_v_q && !redirect_valid_i;
  assign push_data = '{instr: bus.imem_instr_i, pc: rsp_pc_q};

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .aresetn_i   (aresetn_i),
    .push_i      (fifo_push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (redirect_valid_i),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.instr_o = fifo_head.instr;
  assign bus.pc_o    = fifo_head.pc;
  assign bus.valid_o = !fifo_empty;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q   <= IDLE;
      next_pc_q <= RESET_PC;
      rsp_v_q   <= 1'b0;
      rsp_pc_q  <= RESET_PC;
    end else begin
      case (state_q)
        IDLE:    if (fetch_en_i)  state_q <= RUN;
        RUN:     if (!fetch_en_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (redir_issue) begin
        rsp_v_q   <= 1'b1;
        rsp_pc_q  <= tgt;
        next_pc_q <= tgt + PC_INC;
      end else if (redirect_valid_i) begin
        rsp_v_q   <= 1'b0;
        next_pc_q <= tgt;
      end else if (seq_issue) begin
        rsp_v_q   <= 1'b1;
        rsp_pc_q  <= next_pc_q;
        next_pc_q <= next_pc_q + PC_INC;
      end else begin
        rsp_v_q   <= 1'b0;
      end
    end
  end

  // The issue rule reserves a slot for every in-flight read.
  always @(posedge clk_i) begin
    if (aresetn_i) assert (!(fifo_push && fifo_full));
  end

endmodule
